seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Passive decoder for a multiplexed, common-anode 7-segment display bus. It samples the active-low segment lines and the active-low digit enables, and filters out ghosting during digit switching. Each stable glyph is decoded back to a 4-bit hex value per digit position. It sits on the board-facing side of the display driver, or on a captured display header, and gives a self-check or loopback path the numeric value the driver is actually showing.

## Interface
- `DIGITS`, 4: number of multiplexed digit positions (1..8).
- `STABLE`, 4: consecutive identical synchronized samples required before capture (2..255).
- `STALE`, 1000000: cycles without a refresh before a digit's `valid` clears. 0 disables ageing. Width is 24 bits.
- `clk` input, 1: system clock.
- `rst_n` input, 1: asynchronous active-low reset.
- `seg` input, 7: segments gfedcba, active-low. `seg[6]`=g, `seg[0]`=a. Asynchronous to `clk`.
- `an` input, DIGITS: digit enables, active-low; exactly one low while a digit is driven. Asynchronous.
- `hex` output, 4*DIGITS: decoded value. Digit i is at `hex[4i+3:4i]`.
- `valid` output, DIGITS: digit i holds a recognized, non-stale glyph.
- `upd` output, 1: one-cycle pulse on every capture.
- `upd_idx` output, 3: index of the digit captured with `upd`.
- `err` output, 1: one-cycle pulse when a stable pattern matches no glyph.

## Operation
- Input path: `seg` and `an` each pass through a 2-flop synchronizer. All logic below uses the synchronized values.
- Glyph table (`seg` to value):
  - 1000000 to 0, 1111001 to 1, 0100100 to 2, 0110000 to 3
  - 0011001 to 4, 0010010 to 5, 0000010 to 6, 1111000 to 7
  - 0000000 to 8, 0010000 to 9, 0001000 to A, 0000011 to b
  - 1000110 to C, 0100001 to d, 0000110 to E, 0001110 to F
  - 1111111 is blank.
- State machine:
  - **IDLE**: entered when `an` is not one-hot-low (zero or several low). The stability counter is held at 0 and nothing is captured. When `an` becomes one-hot-low, go to FILTER with count=1.
  - **FILTER**: if the {an,seg} sample equals the previous one, count increments; otherwise count=1. Go to IDLE if `an` is not one-hot-low. When count reaches `STABLE`, capture and go to HELD.
  - **HELD**: the glyph has already been captured. Any change in {an,seg} goes to FILTER with count=1, or to IDLE if the new `an` is not one-hot-low. An unchanged sample does not re-capture.
- Capture of a pattern from the glyph table into digit i:
  - `hex` digit i is set to the table value.
  - `valid[i]`=1, `age[i]`=0.
  - `upd`=1, `upd_idx`=i.
- Capture of a blank pattern: `valid[i]`=0, `hex` digit i unchanged, `upd`=1, `err`=0.
- Capture of an unknown pattern: `valid[i]`=0, `hex` digit i unchanged, `upd`=1, `err`=1.
- Ageing (only when `STALE`≠0):
  - Each digit's `age` counter increments while `valid[i]`=1.
  - When `age[i]` reaches `STALE`, `valid[i]` clears. The counter saturates.
  - A capture on the same cycle as expiry wins: `valid` stays 1 and `age` resets to 0.

## Timing
- Reset values:
  - `hex`=0, `valid`=0, `upd`=0, `upd_idx`=0, `err`=0.
  - Synchronizers hold all-ones, i.e. inactive.
  - State is IDLE, all counters are 0.
- Reset mid-operation clears all of the above immediately, asynchronously. Reset release is used synchronously.
- Latency: pins change before edge E0 and then hold. Edge E1 is the first with that value synchronized. Outputs update at edge E(1+STABLE), so `upd` is high in the cycle after that edge. With `STABLE`=4, that is 5 edges after E0.
- A glitch shorter than `STABLE` synchronized cycles never produces `upd`.
- Digit switching with a one-cycle overlap (two anodes low) returns to IDLE and restarts filtering.
- `upd` and `err` are single-cycle pulses. They are never high on back-to-back cycles, because a capture needs at least `STABLE`≥2 samples.

## Configuration
- `SEG7_DP_EN` defined:
  - Adds input `dp` (1 bit, active-low, synchronized like `seg`) and output `dp_out` (DIGITS bits, reset 0).
  - `dp` is part of the compared sample.
  - On capture, `dp_out[i]` becomes `~dp` for both recognized and blank glyphs. It is unchanged on an unknown glyph.
- `SEG7_DP_EN` undefined: neither port exists, and the decimal point does not affect stability or decoding.

## Test plan
- **Single digit:** `an`=1110, `seg`=0100100, held 10 cycles → one `upd` with `upd_idx`=0, `hex[3:0]`=2, `valid`=0001, first `upd` 5 edges after E0.
- **Scan:** 4-digit scan showing 3,A,b,F with 20 cycles per digit → `hex`=16'hFbA3, `valid`=1111, one `upd` per digit visit.
- **Glitch and overlap:** 3-cycle `seg` glitch gives no `upd`. Two anodes low for 1 cycle gives no capture; the correct digit is captured once the overlap ends.
- **Unknown glyph:** `seg`=1010101 stable on digit 1 → `err` and `upd` pulse once, `valid[1]`=0, `hex[7:4]` unchanged. A blank on digit 1 clears `valid[1]` with `err`=0.
- **Ageing:** `STALE`=50, capture digit 0, then stop driving it (`an` all high) → `valid[0]` falls 50 cycles after capture. A recapture at exactly cycle 50 keeps `valid[0]`=1.
- **Reset mid-filter:** assert `rst_n`=0 at count 3 → all outputs are at reset values within the same cycle. After release, a full `STABLE` window is required before the next `upd`.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Passive decoder for a multiplexed, common-anode 7-segment display bus.
// Samples the active-low segment lines and digit enables, waits for a
// {an,seg} pattern to stay identical for STABLE synchronized cycles (which
// rejects ghosting while the driver switches digits), then decodes the glyph
// back to a 4-bit hex value for that digit position.
//
// Parameters
//   DIGITS : number of multiplexed digit positions (1..8)
//   STABLE : identical synchronized samples required before capture (2..255)
//   STALE  : cycles without refresh before valid[i] clears, 0 disables ageing
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   seg[6:0]  in   segments gfedcba, active-low, asynchronous to clk
//   an        in   digit enables, active-low, asynchronous to clk
//   hex       out  decoded nibble per digit, digit i at hex[4i+3:4i]
//   valid     out  digit i holds a recognized, non-stale glyph
//   upd       out  one-cycle pulse on every capture
//   upd_idx   out  digit index of the capture flagged by upd
//   err       out  one-cycle pulse when a stable pattern matches no glyph
//
// Optional feature (macro SEG7_DP_EN):
//   dp        in   decimal point, active-low, part of the compared sample
//   dp_out    out  captured decimal point per digit (active-high)
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 4,
  parameter logic [23:0] STALE  = 24'd1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
`ifdef SEG7_DP_EN
  input  logic                  dp,
  output logic [DIGITS-1:0]     dp_out,
`endif
  output logic [4*DIGITS-1:0]   hex,
  output logic [DIGITS-1:0]     valid,
  output logic                  upd,
  output logic [2:0]            upd_idx,
  output logic                  err
);

`ifdef SEG7_DP_EN
  localparam int unsigned DP_W = 1;
`else
  localparam int unsigned DP_W = 0;
`endif
  // Sample layout: {an, seg[, dp]}
  localparam int unsigned SW       = DIGITS + 7 + DP_W;
  localparam logic [7:0]  STABLE_C = 8'(STABLE);

  typedef enum logic [1:0] {S_IDLE, S_FILTER, S_HELD} state_e;
  typedef enum logic [1:0] {GLYPH_HEX, GLYPH_BLANK, GLYPH_UNKNOWN} glyph_kind_e;
  typedef struct packed {
    glyph_kind_e kind;
    logic [3:0]  value;
  } glyph_t;

  function automatic glyph_t decode_glyph(input logic [6:0] s);
    glyph_t g;
    g.kind  = GLYPH_HEX;
    g.value = 4'h0;
    case (s)
      7'b1000000: g.value = 4'h0;
      7'b1111001: g.value = 4'h1;
      7'b0100100: g.value = 4'h2;
      7'b0110000: g.value = 4'h3;
      7'b0011001: g.value = 4'h4;
      7'b0010010: g.value = 4'h5;
      7'b0000010: g.value = 4'h6;
      7'b1111000: g.value = 4'h7;
      7'b0000000: g.value = 4'h8;
      7'b0010000: g.value = 4'h9;
      7'b0001000: g.value = 4'hA;
      7'b0000011: g.value = 4'hB;
      7'b1000110: g.value = 4'hC;
      7'b0100001: g.value = 4'hD;
      7'b0000110: g.value = 4'hE;
      7'b0001110: g.value = 4'hF;
      7'b1111111: g.kind  = GLYPH_BLANK;
      default:    g.kind  = GLYPH_UNKNOWN;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------- input path
  logic [SW-1:0] raw_sample;
  logic [SW-1:0] sync1_q, sync2_q, prev_q;

`ifdef SEG7_DP_EN
  assign raw_sample = {an, seg, dp};
`else
  assign raw_sample = {an, seg};
`endif

  // Synchronizers idle at all-ones so reset looks like "nothing driven".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      sync1_q <= raw_sample;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  logic [DIGITS-1:0] an_s;
  logic [6:0]        seg_s;
  logic              an_ok;
  logic              same;
  logic [2:0]        digit_idx;

  assign an_s  = sync2_q[SW-1 -: DIGITS];
  assign seg_s = sync2_q[DP_W +: 7];
  assign an_ok = $onehot(~an_s);
  assign same  = (sync2_q == prev_q);

  always_comb begin
    digit_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_s[i]) digit_idx = 3'(i);
    end
  end

  // ------------------------------------------------------------- filter FSM
  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default at the top so no path infers a latch.
    state_d = state_q;
    count_d = count_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (an_ok) begin
          state_d = S_FILTER;
          count_d = 8'd1;
        end
      end
      S_FILTER: begin
        if (!an_ok) begin
          state_d = S_IDLE;
          count_d = '0;
        end else begin
          count_d = same ? count_q + 8'd1 : 8'd1;
          if (count_d == STABLE_C) begin
            capture = 1'b1;
            state_d = S_HELD;
          end
        end
      end
      S_HELD: begin
        // Already captured; only a change in the sample restarts filtering.
        if (!same) begin
          state_d = an_ok ? S_FILTER : S_IDLE;
          count_d = an_ok ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------- datapath
  logic [4*DIGITS-1:0] hex_q, hex_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [23:0]         age_q [DIGITS];
  logic [23:0]         age_d [DIGITS];
  logic                upd_q, upd_d, err_q, err_d;
  logic [2:0]          upd_idx_q, upd_idx_d;
  glyph_t              glyph;
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]   dp_out_q, dp_out_d;
`endif

  assign glyph = decode_glyph(seg_s);

  always_comb begin
    hex_d     = hex_q;
    valid_d   = valid_q;
    age_d     = age_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    upd_idx_d = upd_idx_q;
`ifdef SEG7_DP_EN
    dp_out_d  = dp_out_q;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (STALE != 24'd0 && valid_q[i]) begin
        if (age_q[i] != STALE) age_d[i] = age_q[i] + 24'd1;
        if (age_d[i] == STALE) valid_d[i] = 1'b0;
      end
      // During a capture an_s is one-hot-low, so ~an_s selects the digit.
      // A capture overrides expiry on the same cycle.
      if (capture && !an_s[i]) begin
        valid_d[i] = (glyph.kind == GLYPH_HEX);
        if (glyph.kind == GLYPH_HEX) begin
          hex_d[4*i +: 4] = glyph.value;
          age_d[i]        = '0;
        end
`ifdef SEG7_DP_EN
        if (glyph.kind != GLYPH_UNKNOWN) dp_out_d[i] = ~sync2_q[0];
`endif
      end
    end
    if (capture) begin
      upd_d     = 1'b1;
      upd_idx_d = digit_idx;
      err_d     = (glyph.kind == GLYPH_UNKNOWN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q     <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      upd_idx_q <= '0;
      // NOTE: the per-digit age counters are few, so they are reset like ordinary flops rather than treated as memory.
      for (int i = 0; i < DIGITS; i++) age_q[i] <= '0;
`ifdef SEG7_DP_EN
      dp_out_q  <= '0;
`endif
    end else begin
      hex_q     <= hex_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      upd_idx_q <= upd_idx_d;
      for (int i = 0; i < DIGITS; i++) age_q[i] <= age_d[i];
`ifdef SEG7_DP_EN
      dp_out_q  <= dp_out_d;
`endif
    end
  end

  assign hex     = hex_q;
  assign valid   = valid_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;
  assign err     = err_q;
`ifdef SEG7_DP_EN
  assign dp_out  = dp_out_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Two decoders share one stimulus bus: dut_a with the default STALE and
// dut_b with STALE=50 for ageing. A behavioural model (run-length of
// identical synchronized samples plus a glyph lookup table) predicts every
// output and is compared on each falling edge; directed sections add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  localparam int D  = 4;
  localparam int ST = 4;

  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk, rst_n;
  logic [6:0]   seg;
  logic [D-1:0] an;

  logic [4*D-1:0] hex_a, hex_b;
  logic [D-1:0]   valid_a, valid_b;
  logic           upd_a, upd_b, err_a, err_b;
  logic [2:0]     upd_idx_a, upd_idx_b;

  seg7_scan_decoder #(.DIGITS(D), .STABLE(ST)) dut_a (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .hex(hex_a), .valid(valid_a), .upd(upd_a), .upd_idx(upd_idx_a), .err(err_a)
  );

  seg7_scan_decoder #(.DIGITS(D), .STABLE(ST), .STALE(24'd50)) dut_b (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .hex(hex_b), .valid(valid_b), .upd(upd_b), .upd_idx(upd_idx_b), .err(err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;
  logic chk_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- reference model
  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // 0..15 = hex value, 16 = blank, -1 = unknown
  function automatic int glyph_of(input logic [6:0] s);
    for (int v = 0; v < 16; v++) if (glyph_tab[v] == s) return v;
    return (s == 7'h7F) ? 16 : -1;
  endfunction

  logic [D+6:0] m_s1, m_s2, m_last, m_cur;
  int           m_run, m_zeros, m_dig, m_g;
  logic [3:0]   m_hex [D];
  logic [D-1:0] m_valid [2];
  int           m_age [2][D];
  int           m_stale [2] = '{1000000, 50};
  logic         m_upd, m_err;
  logic [2:0]   m_idx;

  // Capture when the sample seen by the decoder (pins delayed by two clocks)
  // has an exactly-one-low anode and has been identical for exactly ST cycles.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = '1; m_s2 = '1; m_last = '1; m_run = 0;
      m_upd = 1'b0; m_err = 1'b0; m_idx = '0;
      for (int i = 0; i < D; i++) begin
        m_hex[i] = '0;
        for (int k = 0; k < 2; k++) begin
          m_valid[k][i] = 1'b0;
          m_age[k][i]   = 0;
        end
      end
    end else begin
      m_cur  = m_s2;
      m_run  = (m_cur == m_last) ? m_run + 1 : 1;
      m_last = m_cur;
      m_upd  = 1'b0;
      m_err  = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < D; i++)
          if (m_valid[k][i]) begin
            if (m_age[k][i] < m_stale[k]) m_age[k][i]++;
            if (m_age[k][i] >= m_stale[k]) m_valid[k][i] = 1'b0;
          end
      m_zeros = 0;
      m_dig   = 0;
      for (int i = 0; i < D; i++)
        if (!m_cur[7+i]) begin
          m_zeros++;
          m_dig = i;
        end
      if (m_zeros == 1 && m_run == ST) begin
        m_g   = glyph_of(m_cur[6:0]);
        m_upd = 1'b1;
        m_idx = 3'(m_dig);
        if (m_g >= 0 && m_g < 16) begin
          m_hex[m_dig] = 4'(m_g);
          for (int k = 0; k < 2; k++) begin
            m_valid[k][m_dig] = 1'b1;
            m_age[k][m_dig]   = 0;
          end
        end else begin
          for (int k = 0; k < 2; k++) m_valid[k][m_dig] = 1'b0;
          m_err = (m_g < 0);
        end
      end
      m_s2 = m_s1;
      m_s1 = {an, seg};
    end
  end

  // ------------------------------------------------------ compare process
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("hex_a",   32'(hex_a),   32'({m_hex[3], m_hex[2], m_hex[1], m_hex[0]}));
      check("hex_b",   32'(hex_b),   32'({m_hex[3], m_hex[2], m_hex[1], m_hex[0]}));
      check("valid_a", 32'(valid_a), 32'(m_valid[0]));
      check("valid_b", 32'(valid_b), 32'(m_valid[1]));
      check("upd_a",   32'(upd_a),   32'(m_upd));
      check("upd_b",   32'(upd_b),   32'(m_upd));
      check("err_a",   32'(err_a),   32'(m_err));
      check("err_b",   32'(err_b),   32'(m_err));
      if (m_upd) begin
        check("upd_idx_a", 32'(upd_idx_a), 32'(m_idx));
        check("upd_idx_b", 32'(upd_idx_b), 32'(m_idx));
      end
    end
  end

  // Pulse counters for the directed literal checks (read half a cycle later).
  int upd_cnt = 0, err_cnt = 0;
  logic [2:0] last_idx = '0;
  initial forever begin
    @(negedge clk);
    if (upd_a) begin
      upd_cnt++;
      last_idx = upd_idx_a;
    end
    if (err_a) err_cnt++;
  end

  // Called just after a falling edge; returns just after a falling edge.
  task automatic drive(input logic [D-1:0] a, input logic [6:0] s, input int cycles);
    an  = a;
    seg = s;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  logic [D-1:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0]   scan_seg [4] = '{SEG_3, SEG_A, SEG_B, SEG_F};
  int n, base_upd, base_err;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    an = '1; seg = '1; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hex",     32'(hex_a),     32'h0);
    check("rst_valid",   32'(valid_a),   32'h0);
    check("rst_upd",     32'(upd_a),     32'h0);
    check("rst_err",     32'(err_a),     32'h0);
    check("rst_upd_idx", 32'(upd_idx_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'hF, BLANK, 3);

    // Single digit: n counts edges with E0 as 1, so "5 edges after E0" is n=6.
    base_upd = upd_cnt;
    an = 4'b1110; seg = SEG_2;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!upd_a && n < 12);
    check("single_latency", 32'(n), 32'd6);
    check("single_idx",     32'(upd_idx_a), 32'd0);
    check("single_hex",     32'(hex_a[3:0]), 32'h2);
    check("single_valid",   32'(valid_a), 32'b0001);
    @(negedge clk);
    drive(4'b1110, SEG_2, 4);
    check("single_upd_cnt", 32'(upd_cnt - base_upd), 32'd1);

    // Scan 3,A,b,F over three rounds.
    base_upd = upd_cnt;
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) drive(scan_an[d], scan_seg[d], 20);
    check("scan_upd_cnt", 32'(upd_cnt - base_upd), 32'd12);
    check("scan_hex",     32'(hex_a), 32'hFBA3);
    check("scan_valid",   32'(valid_a), 32'hF);

    // 3-cycle glitch: only the restored '3' re-captures, later.
    drive(4'b1110, SEG_3, 10);
    base_upd = upd_cnt;
    drive(4'b1110, 7'b0000000, 3);
    drive(4'b1110, SEG_3, 4);
    check("glitch_no_upd", 32'(upd_cnt - base_upd), 32'd0);
    drive(4'b1110, SEG_3, 6);
    check("glitch_restore_upd", 32'(upd_cnt - base_upd), 32'd1);
    check("glitch_hex0",        32'(hex_a[3:0]), 32'h3);

    // One-cycle anode overlap, then digit 1 shows '7'.
    base_upd = upd_cnt;
    drive(4'b1100, SEG_7, 1);
    drive(4'b1101, SEG_7, 12);
    check("overlap_upd_cnt", 32'(upd_cnt - base_upd), 32'd1);
    check("overlap_idx",     32'(last_idx), 32'd1);
    check("overlap_hex",     32'(hex_a), 32'hFB73);

    // Unknown glyph on digit 1, then a real glyph, then blank.
    base_upd = upd_cnt; base_err = err_cnt;
    drive(4'b1101, 7'b1010101, 10);
    check("unk_upd_cnt", 32'(upd_cnt - base_upd), 32'd1);
    check("unk_err_cnt", 32'(err_cnt - base_err), 32'd1);
    check("unk_valid1",  32'(valid_a[1]), 32'd0);
    check("unk_hex1",    32'(hex_a[7:4]), 32'h7);
    drive(4'b1101, SEG_5, 10);
    check("refill_valid1", 32'(valid_a[1]), 32'd1);
    check("refill_hex1",   32'(hex_a[7:4]), 32'h5);
    base_upd = upd_cnt; base_err = err_cnt;
    drive(4'b1101, BLANK, 10);
    check("blank_valid1",  32'(valid_a[1]), 32'd0);
    check("blank_upd_cnt", 32'(upd_cnt - base_upd), 32'd1);
    check("blank_err_cnt", 32'(err_cnt - base_err), 32'd0);
    check("blank_hex1",    32'(hex_a[7:4]), 32'h5);

    // Ageing on dut_b (STALE=50): valid falls 50 edges after the capture edge.
    an = 4'b1110; seg = SEG_5;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!upd_b && n < 12);
    check("age_capture", 32'(upd_b), 32'd1);
    @(negedge clk);
    an = 4'hF;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (valid_b[0] && n < 100);
    check("age_fall_cycles", 32'(n), 32'd50);
    check("age_long_stale_a", 32'(valid_a[0]), 32'd1);
    check("age_hex_b",        32'(hex_b[3:0]), 32'h5);

    // Recapture landing exactly on the expiry edge keeps valid.
    @(negedge clk);
    an = 4'b1110; seg = SEG_6;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!upd_b && n < 12);
    check("age_recap_first", 32'(upd_b), 32'd1);
    @(negedge clk);
    an = 4'hF;
    repeat (44) @(negedge clk);
    an = 4'b1110; seg = SEG_6;
    repeat (5) @(posedge clk);
    #1;
    check("age_before_expiry", 32'(valid_b[0]), 32'd1);
    @(posedge clk);
    #1;
    check("age_recap_upd",   32'(upd_b), 32'd1);
    check("age_recap_valid", 32'(valid_b[0]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("age_recap_hold", 32'(valid_b[0]), 32'd1);

    // Reset mid-filter (count 3), then a full window again after release.
    @(negedge clk);
    an = 4'b1011; seg = SEG_9;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hex",   32'(hex_a),   32'h0);
    check("midrst_valid", 32'(valid_a), 32'h0);
    check("midrst_vb",    32'(valid_b), 32'h0);
    check("midrst_upd",   32'(upd_a),   32'h0);
    check("midrst_err",   32'(err_a),   32'h0);
    check("midrst_idx",   32'(upd_idx_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!upd_a && n < 12);
    check("postrst_latency", 32'(n), 32'd6);
    check("postrst_hex",     32'(hex_a), 32'h0900);
    check("postrst_valid",   32'(valid_a), 32'b0100);

    // Randomized traffic: scans, overlaps, blanks, garbage, short holds.
    @(negedge clk);
    for (int r = 0; r < 400; r++) begin
      logic [D-1:0] a;
      logic [6:0]   s;
      int           pick;
      pick = $urandom_range(0, 9);
      if (pick <= 5)      a = ~(4'b0001 << $urandom_range(0, 3));
      else if (pick == 6) a = 4'hF;
      else                a = 4'($urandom);
      pick = $urandom_range(0, 9);
      if (pick <= 6)      s = glyph_tab[$urandom_range(0, 15)];
      else if (pick == 7) s = BLANK;
      else                s = 7'($urandom);
      drive(a, s, $urandom_range(1, 9));
    end
    drive(4'hF, BLANK, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
